// File: rtl/counter_session_arbiter.sv
// Round-robin sequencer for the start/stop modulo-MOD event counter.
// Grants sessions, issues start/stop, waits for the stop echo, pulses done.
module counter_session_arbiter #(
    parameter int MOD     = 14,
    parameter int LEN_MAX = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [3:0] count,
    input  logic       stop_d2,
    output logic       start,
    output logic       stop,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic [3:0] end_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] LMAX = 4'(LEN_MAX);
    localparam logic [4:0] MODV = 5'(MOD);

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       ptr_q, ptr_d;
    logic [3:0] len_q, len_d;
    logic [3:0] pre_q, pre_d;
    logic [3:0] end_q, end_d;

    logic       pick1;
    logic [3:0] len_sel;
    logic [3:0] len_clamp;
    logic [4:0] sum;
    logic [4:0] pre_w;

    // Winner select, length clamp and wrapped pre-stop count.
    always_comb begin
        pick1     = req[1] & (~req[0] | ptr_q);
        len_sel   = pick1 ? len1 : len0;
        len_clamp = (len_sel > LMAX) ? LMAX : len_sel;
        sum       = {1'b0, count} + {1'b0, len_q} - 5'd1;
        pre_w     = (sum >= MODV) ? (sum - MODV) : sum;
    end

    // Next-state and outputs; ptr_q set means requester 1 wins a tie.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        pre_d   = pre_q;
        end_d   = end_q;
        start   = 1'b0;
        stop    = 1'b0;
        done    = 2'b00;
        busy    = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    len_d   = len_clamp;
                    state_d = (len_clamp == 4'd0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                start   = 1'b1;
                pre_d   = pre_w[3:0];
                state_d = S_RUN;
            end
            S_RUN: begin
                if (count == pre_q) begin
                    stop    = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (stop_d2) begin
                    end_d   = count;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = gnt_q;
                ptr_d   = gnt_q[0];
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and session registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            ptr_q   <= 1'b0;
            len_q   <= 4'd0;
            pre_q   <= 4'd0;
            end_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            pre_q   <= pre_d;
            end_q   <= end_d;
        end
    end

    assign gnt       = gnt_q;
    assign end_count = end_q;

endmodule

// File: tb/tb_counter_session_arbiter.sv
// Directed bench for counter_session_arbiter with a behavioural
// start/stop modulo-14 counter attached.
module tb_counter_session_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0, len1;
    logic [3:0] count;
    logic       stop_d2;
    logic       start, stop, busy;
    logic [1:0] gnt, done;
    logic [3:0] end_count;

    logic       en, s1;
    logic       ld;
    logic [3:0] ld_val;
    logic       overlap_seen = 1'b0;

    int checks = 0;
    int errors = 0;

    counter_session_arbiter #(.MOD(14), .LEN_MAX(14)) dut (
        .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
        .count(count), .stop_d2(stop_d2), .start(start), .stop(stop),
        .gnt(gnt), .done(done), .busy(busy), .end_count(end_count)
    );

    always #5 clk = ~clk;

    // Counter model: enable set by start, cleared by stop; stop echoed
    // two cycles later; ld is a bench-only preload.
    always @(posedge clk) begin
        if (!reset) begin
            count   <= 4'd0;
            en      <= 1'b0;
            s1      <= 1'b0;
            stop_d2 <= 1'b0;
        end else begin
            s1      <= stop;
            stop_d2 <= s1;
            if (ld)
                count <= ld_val;
            else if (en)
                count <= (count == 4'd13) ? 4'd0 : count + 4'd1;
            if (start)
                en <= 1'b1;
            else if (stop)
                en <= 1'b0;
        end
    end

    always @(negedge clk)
        if (reset === 1'b1 && start === 1'b1 && stop === 1'b1)
            overlap_seen = 1'b1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; req = 2'b00; len0 = 4'd0; len1 = 4'd0;
        ld = 1'b0; ld_val = 4'd0;
        step(2);
        chk("rst_start", 4'(start), 4'd0);
        chk("rst_stop", 4'(stop), 4'd0);
        chk("rst_gnt", 4'(gnt), 4'd0);
        chk("rst_done", 4'(done), 4'd0);
        chk("rst_busy", 4'(busy), 4'd0);
        chk("rst_end", end_count, 4'd0);
        reset = 1'b1;
        step(1);

        // single session, len0=5 from count 0
        req = 2'b01; len0 = 4'd5;
        chk("s1_idle_busy", 4'(busy), 4'd0);
        step(1);
        chk("s1_start", 4'(start), 4'd1);
        chk("s1_gnt", 4'(gnt), 4'd1);
        chk("s1_busy", 4'(busy), 4'd1);
        chk("s1_nostop", 4'(stop), 4'd0);
        req = 2'b00; len0 = 4'd7;
        step(4);
        chk("s1_stop_early", 4'(stop), 4'd0);
        step(1);
        chk("s1_stop", 4'(stop), 4'd1);
        chk("s1_stop_cnt", count, 4'd4);
        step(1);
        chk("s1_stop_off", 4'(stop), 4'd0);
        chk("s1_gnt_hold", 4'(gnt), 4'd1);
        step(2);
        chk("s1_done", 4'(done), 4'd1);
        step(1);
        chk("s1_done_off", 4'(done), 4'd0);
        chk("s1_idle", 4'(busy), 4'd0);
        chk("s1_gnt_clr", 4'(gnt), 4'd0);
        chk("s1_end", end_count, 4'd5);
        chk("s1_cnt_hold", count, 4'd5);

        // wrap: requester 1, len1=6 from count 11
        ld = 1'b1; ld_val = 4'd11;
        step(1);
        ld = 1'b0;
        req = 2'b10; len1 = 4'd6;
        step(1);
        chk("w_start", 4'(start), 4'd1);
        chk("w_gnt", 4'(gnt), 4'd2);
        req = 2'b00;
        step(6);
        chk("w_stop", 4'(stop), 4'd1);
        chk("w_stop_cnt", count, 4'd2);
        step(3);
        chk("w_done", 4'(done), 4'd2);
        step(1);
        chk("w_end", end_count, 4'd3);
        chk("w_idle", 4'(busy), 4'd0);

        // round robin: both requesting, len=2, count from 0
        ld = 1'b1; ld_val = 4'd0;
        step(1);
        ld = 1'b0;
        req = 2'b11; len0 = 4'd2; len1 = 4'd2;
        step(1);
        chk("rr1_gnt", 4'(gnt), 4'd1);
        step(5);
        chk("rr1_done", 4'(done), 4'd1);
        step(1);
        chk("rr1_end", end_count, 4'd2);
        chk("rr1_idle", 4'(busy), 4'd0);
        step(1);
        chk("rr2_gnt", 4'(gnt), 4'd2);
        step(5);
        chk("rr2_done", 4'(done), 4'd2);
        step(1);
        chk("rr2_end", end_count, 4'd4);
        step(1);
        chk("rr3_gnt", 4'(gnt), 4'd1);
        req = 2'b00;
        step(5);
        chk("rr3_done", 4'(done), 4'd1);
        step(1);
        chk("rr3_end", end_count, 4'd6);
        chk("rr3_idle", 4'(busy), 4'd0);

        // clamp: len0=15 -> 14 ticks from count 6
        req = 2'b01; len0 = 4'd15;
        step(1);
        chk("cl_start", 4'(start), 4'd1);
        req = 2'b00;
        step(13);
        chk("cl_stop_early", 4'(stop), 4'd0);
        step(1);
        chk("cl_stop", 4'(stop), 4'd1);
        chk("cl_stop_cnt", count, 4'd5);
        step(3);
        chk("cl_done", 4'(done), 4'd1);
        step(1);
        chk("cl_end", end_count, 4'd6);
        chk("cl_cnt", count, 4'd6);

        // zero length
        req = 2'b01; len0 = 4'd0;
        step(1);
        chk("z_done", 4'(done), 4'd1);
        chk("z_nostart", 4'(start), 4'd0);
        chk("z_gnt", 4'(gnt), 4'd1);
        req = 2'b00;
        step(1);
        chk("z_done_off", 4'(done), 4'd0);
        chk("z_idle", 4'(busy), 4'd0);
        chk("z_nostart2", 4'(start), 4'd0);
        chk("z_end", end_count, 4'd6);

        // reset during RUN
        req = 2'b01; len0 = 4'd9;
        step(1);
        chk("r_start", 4'(start), 4'd1);
        req = 2'b00;
        step(3);
        chk("r_run_busy", 4'(busy), 4'd1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("r_gnt", 4'(gnt), 4'd0);
        chk("r_busy", 4'(busy), 4'd0);
        chk("r_stop", 4'(stop), 4'd0);
        chk("r_done", 4'(done), 4'd0);
        chk("r_end", end_count, 4'd0);
        chk("r_cnt", count, 4'd0);
        for (int i = 0; i < 14; i++) begin
            step(1);
            chk("r_nodone", 4'(done), 4'd0);
        end
        req = 2'b01; len0 = 4'd3;
        step(1);
        chk("r2_start", 4'(start), 4'd1);
        req = 2'b00;
        step(3);
        chk("r2_stop", 4'(stop), 4'd1);
        chk("r2_stop_cnt", count, 4'd2);
        step(3);
        chk("r2_done", 4'(done), 4'd1);
        step(1);
        chk("r2_end", end_count, 4'd3);

        // request dropped during RUN, count from 3
        req = 2'b10; len1 = 4'd4;
        step(1);
        chk("d_gnt", 4'(gnt), 4'd2);
        step(2);
        chk("d_busy", 4'(busy), 4'd1);
        req = 2'b00; len1 = 4'd1;
        step(2);
        chk("d_stop", 4'(stop), 4'd1);
        chk("d_stop_cnt", count, 4'd6);
        step(3);
        chk("d_done", 4'(done), 4'd2);
        step(1);
        chk("d_end", end_count, 4'd7);
        chk("d_idle", 4'(busy), 4'd0);

        chk("no_overlap", 4'(overlap_seen), 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
